sram_arbiter: RTL and testbench

- Shares the single external 21-bit-address / 8-bit-data SRAM bus between three requesters: ROM/disk download (ioctl path), video fetch, and the CPU.
- Sits between the Next186Lite core's memory clients and the SRAM_A / SRAM_D / SRAM_WE_n pins.
- Owns the pins exclusively, sequences each access with fixed timing, and returns per-port acknowledges and read data.

---
 rtl/sram_arb_pkg.sv | 28 ++
 rtl/sram_arbiter_if.sv | 56 +++++
 rtl/sram_arb_select.sv | 53 +++++
 rtl/sram_arbiter.sv | 153 +++++++++++++++
 tb/tb_sram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: bus widths, port/state enums
// and the pending-request record latched per requester.
package sram_arb_pkg;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 8;
  localparam int NPORT  = 3;

  typedef enum logic [1:0] {
    PORT_DL  = 2'd0,
    PORT_VID = 2'd1,
    PORT_CPU = 2'd2
  } port_e;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Request/ack bus of the three SRAM clients plus the SRAM pin bundle.
// slave: arbiter side; master: clients + SRAM side.
interface sram_arbiter_if;
  import sram_arb_pkg::*;

  logic              dl_stb;
  logic [ADDR_W-1:0] dl_addr;
  logic [DATA_W-1:0] dl_wdata;
  logic              dl_busy;
  logic              dl_ack;

  logic              vid_stb;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_busy;
  logic              vid_ack;

  logic              cpu_stb;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_busy;
  logic              cpu_ack;

  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_dout;
  logic [DATA_W-1:0] sram_din;
  logic              sram_oe;
  logic              sram_we_n;

  modport slave (
    input  dl_stb, dl_addr, dl_wdata,
    output dl_busy, dl_ack,
    input  vid_stb, vid_addr,
    output vid_busy, vid_ack,
    input  cpu_stb, cpu_we, cpu_addr, cpu_wdata,
    output cpu_busy, cpu_ack,
    output rdata,
    output sram_a, sram_dout, sram_oe, sram_we_n,
    input  sram_din
  );

  modport master (
    output dl_stb, dl_addr, dl_wdata,
    input  dl_busy, dl_ack,
    output vid_stb, vid_addr,
    input  vid_busy, vid_ack,
    output cpu_stb, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_busy, cpu_ack,
    input  rdata,
    input  sram_a, sram_dout, sram_oe, sram_we_n,
    output sram_din
  );

endinterface

// File: rtl/sram_arb_select.sv
// Priority pick among pending ports with a CPU anti-starvation streak.
// Ports: clk_sys, reset, pend_i, take_i -> win_o, valid_o.
module sram_arb_select
  import sram_arb_pkg::*;
#(
  parameter int MAX_VID_STREAK = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [NPORT-1:0] pend_i,
  input  logic             take_i,
  output port_e            win_o,
  output logic             valid_o
);

  localparam logic [3:0] SMAX = 4'(MAX_VID_STREAK);

  logic [3:0] streak_q, streak_d;
  logic       sel_dl, sel_cf, sel_vid;

  // Conditions are made mutually exclusive so the decoder is unique;
  // the forced-CPU case and plain CPU both fall to the default arm.
  always_comb begin
    sel_dl  = pend_i[PORT_DL];
    sel_cf  = !sel_dl && pend_i[PORT_CPU]
              && (streak_q == SMAX);
    sel_vid = !sel_dl && !sel_cf && pend_i[PORT_VID];
    valid_o = |pend_i;
    unique case (1'b1)
      sel_dl:  win_o = PORT_DL;
      sel_vid: win_o = PORT_VID;
      default: win_o = PORT_CPU;
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (!pend_i[PORT_CPU]) begin
      streak_d = '0;
    end else if (take_i && win_o == PORT_CPU) begin
      streak_d = '0;
    end else if (take_i && win_o == PORT_VID
                 && streak_q != SMAX) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) streak_q <= '0;
    else       streak_q <= streak_d;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Three-port SRAM arbiter (download, video, CPU) with fixed access timing.
// Ports: clk_sys, reset, bus (sram_arbiter_if.slave: requests, acks, pins).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES  = 2,
  parameter int MAX_VID_STREAK = 4
) (
  input  logic clk_sys,
  input  logic reset,
  sram_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  port_e             gnt_q, gnt_d;
  logic [NPORT-1:0]  pv_q, pv_d;
  req_t [NPORT-1:0]  pend_q, pend_d;
  req_t [NPORT-1:0]  nreq;
  logic [NPORT-1:0]  stb;
  logic [NPORT-1:0]  ack_q, ack_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              oe_q, oe_d;
  logic              we_n_q, we_n_d;
  port_e             win;
  logic              valid;
  logic              take;
  req_t              win_req;

  assign take = (state_q == IDLE) && valid;

  sram_arb_select #(
    .MAX_VID_STREAK(MAX_VID_STREAK)
  ) u_sel (
    .clk_sys(clk_sys),
    .reset  (reset),
    .pend_i (pv_q),
    .take_i (take),
    .win_o  (win),
    .valid_o(valid)
  );

  assign stb = {bus.cpu_stb, bus.vid_stb, bus.dl_stb};

  always_comb begin
    nreq[PORT_DL]  = '{addr: bus.dl_addr, we: 1'b1,
                       wdata: bus.dl_wdata};
    nreq[PORT_VID] = '{addr: bus.vid_addr, we: 1'b0,
                       wdata: '0};
    nreq[PORT_CPU] = '{addr: bus.cpu_addr, we: bus.cpu_we,
                       wdata: bus.cpu_wdata};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    pv_d    = pv_q;
    pend_d  = pend_q;
    a_d     = a_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    we_n_d  = we_n_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    win_req = pend_q[win];
    for (int p = 0; p < NPORT; p++) begin
      if (stb[p] && !pv_q[p]) begin
        pv_d[p]   = 1'b1;
        pend_d[p] = nreq[p];
      end
    end
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          gnt_d = win;
          a_d   = win_req.addr;
          oe_d  = win_req.we;
          if (win_req.we) dout_d = win_req.wdata;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_LOAD;
        // oe doubles as the write flag of the access in flight
        we_n_d  = !oe_q;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          we_n_d = 1'b1;
          if (!oe_q) rdata_d = bus.sram_din;
          // busy drops on the same edge that raises ack
          pv_d[gnt_q]  = 1'b0;
          ack_d[gnt_q] = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        oe_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= PORT_DL;
      pv_q    <= '0;
      pend_q  <= '0;
      ack_q   <= '0;
      a_q     <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      pv_q    <= pv_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      a_q     <= a_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
    end
  end

  assign bus.dl_busy   = pv_q[PORT_DL];
  assign bus.vid_busy  = pv_q[PORT_VID];
  assign bus.cpu_busy  = pv_q[PORT_CPU];
  assign bus.dl_ack    = ack_q[PORT_DL];
  assign bus.vid_ack   = ack_q[PORT_VID];
  assign bus.cpu_ack   = ack_q[PORT_CPU];
  assign bus.rdata     = rdata_q;
  assign bus.sram_a    = a_q;
  assign bus.sram_dout = dout_q;
  assign bus.sram_oe   = oe_q;
  assign bus.sram_we_n = we_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an SRAM model and a
// per-access scoreboard checked on every ack.
module tb_sram_arbiter;

  typedef struct {
    int          port;
    logic [20:0] addr;
    logic        we;
    logic [7:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if bus();

  sram_arbiter #(
    .ACCESS_CYCLES (2),
    .MAX_VID_STREAK(4)
  ) dut (
    .clk_sys(clk),
    .reset  (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cpu_acks = 0;
  exp_t sbq[$];
  int order[$];
  int times[$];

  always @(posedge clk) cyc++;

  // SRAM model: preload pattern is addr[7:0] ^ 5A until written
  bit [7:0] mem [256];
  bit       wr_vld [256];
  always @(posedge clk)
    if (!rst && !bus.sram_we_n) begin
      mem[bus.sram_a[7:0]]    <= bus.sram_dout;
      wr_vld[bus.sram_a[7:0]] <= 1'b1;
    end
  assign bus.sram_din = wr_vld[bus.sram_a[7:0]]
                        ? mem[bus.sram_a[7:0]]
                        : (bus.sram_a[7:0] ^ 8'h5A);

  function automatic logic [7:0] initv(input logic [20:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input logic [20:0] a,
                      input logic we, input logic [7:0] d);
    exp_t e;
    e.port = p; e.addr = a; e.we = we; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic cpu_req(input logic we, input logic [20:0] a,
                         input logic [7:0] d);
    bus.cpu_stb = 1'b1; bus.cpu_we = we;
    bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk); n++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  task automatic wait_vid_ack(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.vid_ack && n < budget);
    chk("vid_ack_wait", bus.vid_ack, 1);
  endtask

  // Ack monitor and write-strobe shape checks
  int run = 0;
  logic [20:0] prev_a;
  logic [2:0] av, bv;
  int p, idx;
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
    end else begin
      av = {bus.cpu_ack, bus.vid_ack, bus.dl_ack};
      bv = {bus.cpu_busy, bus.vid_busy, bus.dl_busy};
      if (av != 3'b000) begin
        chk("ack_onehot", $countones(av), 1);
        p = av[0] ? 0 : (av[1] ? 1 : 2);
        chk("busy_at_ack", bv[p], 0);
        idx = -1;
        for (int i = 0; i < sbq.size(); i++)
          if (idx < 0 && sbq[i].port == p) idx = i;
        chk("ack_expected", idx >= 0, 1);
        if (idx >= 0) begin
          e = sbq[idx];
          sbq.delete(idx);
          chk("ack_addr", bus.sram_a, e.addr);
          if (e.we) chk("ack_wdata", bus.sram_dout, e.data);
          else      chk("ack_rdata", bus.rdata, e.data);
        end
        order.push_back(p);
        times.push_back(cyc);
        if (p == 2) cpu_acks++;
      end
      if (!bus.sram_we_n) begin
        run++;
        if (run > 1) chk("we_addr_stable", bus.sram_a, prev_a);
      end else if (run != 0) begin
        chk("we_width", run, 2);
        run = 0;
      end
      prev_a = bus.sram_a;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [4:0] we_tab, ack_tab, busy_tab;
    int exp_ord [7];
    int n, acks0;

    bus.dl_stb = 0; bus.dl_addr = '0; bus.dl_wdata = '0;
    bus.vid_stb = 0; bus.vid_addr = '0;
    bus.cpu_stb = 0; bus.cpu_we = 0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_we_n", bus.sram_we_n, 1);
    chk("rst_oe", bus.sram_oe, 0);
    chk("rst_a", bus.sram_a, 0);
    chk("rst_dout", bus.sram_dout, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_busy", {bus.cpu_busy, bus.vid_busy, bus.dl_busy}, 0);
    chk("rst_ack", {bus.cpu_ack, bus.vid_ack, bus.dl_ack}, 0);
    rst = 1'b0;
    @(negedge clk);

    // single CPU write, cycle-by-cycle
    we_tab = 5'b10011; ack_tab = 5'b10000; busy_tab = 5'b01111;
    cpu_req(1'b1, 21'h12345, 8'hA5);
    push(2, 21'h12345, 1'b1, 8'hA5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus.cpu_stb = 0;
      chk("wr_we_n", bus.sram_we_n, we_tab[k-1]);
      chk("wr_ack", bus.cpu_ack, ack_tab[k-1]);
      chk("wr_busy", bus.cpu_busy, busy_tab[k-1]);
      if (k >= 2) begin
        chk("wr_a", bus.sram_a, 21'h12345);
        chk("wr_dout", bus.sram_dout, 8'hA5);
        chk("wr_oe", bus.sram_oe, 1);
      end
    end
    @(negedge clk);
    chk("wr_oe_clr", bus.sram_oe, 0);

    // CPU read back
    cpu_req(1'b0, 21'h12345, 8'h00);
    push(2, 21'h12345, 1'b0, 8'hA5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus.cpu_stb = 0;
      chk("rd_oe", bus.sram_oe, 0);
    end
    chk("rd_ack_lat", bus.cpu_ack, 1);
    wait_drain(10);

    // simultaneous strobes
    order.delete(); times.delete();
    @(negedge clk);
    bus.dl_stb = 1; bus.dl_addr = 21'h00310; bus.dl_wdata = 8'h3C;
    bus.vid_stb = 1; bus.vid_addr = 21'h00320;
    cpu_req(1'b0, 21'h00310, 8'h00);
    push(0, 21'h00310, 1'b1, 8'h3C);
    push(1, 21'h00320, 1'b0, initv(21'h00320));
    push(2, 21'h00310, 1'b0, 8'h3C);
    @(negedge clk);
    bus.dl_stb = 0; bus.vid_stb = 0; bus.cpu_stb = 0;
    chk("all_busy", {bus.cpu_busy, bus.vid_busy, bus.dl_busy}, 3'b111);
    wait_drain(40);
    chk("sim_cnt", order.size(), 3);
    if (order.size() == 3) begin
      chk("sim_ord0", order[0], 0);
      chk("sim_ord1", order[1], 1);
      chk("sim_ord2", order[2], 2);
      chk("sim_gap1", times[1] - times[0], 5);
      chk("sim_gap2", times[2] - times[1], 5);
    end

    // video streak against a pending CPU read
    order.delete(); times.delete();
    exp_ord = '{1, 1, 1, 1, 2, 1, 1};
    @(negedge clk);
    bus.vid_stb = 1; bus.vid_addr = 21'h00701;
    cpu_req(1'b0, 21'h00310, 8'h00);
    push(1, 21'h00701, 1'b0, initv(21'h00701));
    push(2, 21'h00310, 1'b0, 8'h3C);
    @(negedge clk);
    bus.vid_stb = 0; bus.cpu_stb = 0;
    for (int r = 0; r < 5; r++) begin
      wait_vid_ack(30);
      bus.vid_stb = 1;
      bus.vid_addr = 21'h00702 + 21'(r);
      push(1, bus.vid_addr, 1'b0, initv(bus.vid_addr));
      @(negedge clk);
      bus.vid_stb = 0;
    end
    wait_drain(60);
    chk("stk_cnt", order.size(), 7);
    if (order.size() == 7)
      for (int i = 0; i < 7; i++) chk("stk_ord", order[i], exp_ord[i]);

    // strobe while busy is ignored
    acks0 = cpu_acks;
    cpu_req(1'b1, 21'h00488, 8'h77);
    push(2, 21'h00488, 1'b1, 8'h77);
    @(negedge clk);
    chk("ign_busy", bus.cpu_busy, 1);
    cpu_req(1'b1, 21'h00499, 8'h11);
    @(negedge clk);
    bus.cpu_stb = 0;
    wait_drain(30);
    repeat (8) @(negedge clk);
    chk("ign_acks", cpu_acks - acks0, 1);
    cpu_req(1'b0, 21'h00488, 8'h00);
    push(2, 21'h00488, 1'b0, 8'h77);
    @(negedge clk);
    bus.cpu_stb = 0;
    wait_drain(30);
    cpu_req(1'b0, 21'h00499, 8'h00);
    push(2, 21'h00499, 1'b0, initv(21'h00499));
    @(negedge clk);
    bus.cpu_stb = 0;
    wait_drain(30);

    // async reset in the middle of a write
    cpu_req(1'b1, 21'h000AA, 8'h55);
    push(2, 21'h000AA, 1'b1, 8'h55);
    @(negedge clk);
    bus.cpu_stb = 0;
    n = 0;
    do begin @(negedge clk); n++; end
    while (bus.sram_we_n && n < 10);
    chk("pre_rst_we_n", bus.sram_we_n, 0);
    acks0 = cpu_acks;
    rst = 1'b1;
    #1;
    chk("mid_rst_we_n", bus.sram_we_n, 1);
    chk("mid_rst_oe", bus.sram_oe, 0);
    chk("mid_rst_busy", {bus.cpu_busy, bus.vid_busy, bus.dl_busy}, 0);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_acks", cpu_acks - acks0, 0);
    chk("post_rst_busy", {bus.cpu_busy, bus.vid_busy, bus.dl_busy}, 0);
    cpu_req(1'b1, 21'h000BB, 8'h42);
    push(2, 21'h000BB, 1'b1, 8'h42);
    @(negedge clk);
    bus.cpu_stb = 0;
    wait_drain(30);
    cpu_req(1'b0, 21'h000BB, 8'h00);
    push(2, 21'h000BB, 1'b0, 8'h42);
    @(negedge clk);
    bus.cpu_stb = 0;
    wait_drain(30);
    chk("post_rst_acks2", cpu_acks - acks0, 2);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
